// File: rtl/xif_copro_wb_scheduler.sv
// ---------------------------------------------------------------------------
// xif_copro_wb_scheduler
//
// Write-back scheduler for a coprocessor with several result-producing units
// that share a single register-file write port.
//
// A 32-entry scoreboard records which registers have a write in flight.
// Issue is stalled on RAW hazards (a source is busy) and on WAW hazards
// (the destination is busy and will be written).
//
// A round-robin arbiter picks one unit result per cycle. The chosen result
// is registered onto the write port one cycle later. The busy bit for that
// register is cleared on the same edge that the register file commits the
// data.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   issue_valid_i       instruction offered for issue
//   issue_ready_o       instruction may issue this cycle (combinational)
//   issue_rs1_i/rs2_i   source register addresses
//   issue_rd_i          destination register address
//   issue_rd_we_i       instruction writes issue_rd_i
//   res_valid_i         per-unit result valid
//   res_ready_o         per-unit grant, one-hot (combinational)
//   res_waddr_i         per-unit destination address
//   res_wdata_i         per-unit result data
//   rf_we_o             register-file write enable (registered)
//   rf_waddr_o          register-file write address (registered)
//   rf_wdata_o          register-file write data (registered)
//   busy_o              scoreboard, bit i = write to register i pending
// ---------------------------------------------------------------------------
module xif_copro_wb_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NR_UNITS   = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 issue_valid_i,
    output logic                                 issue_ready_o,
    input  logic [4:0]                           issue_rs1_i,
    input  logic [4:0]                           issue_rs2_i,
    input  logic [4:0]                           issue_rd_i,
    input  logic                                 issue_rd_we_i,
    input  logic [NR_UNITS-1:0]                  res_valid_i,
    output logic [NR_UNITS-1:0]                  res_ready_o,
    input  logic [NR_UNITS-1:0][4:0]             res_waddr_i,
    input  logic [NR_UNITS-1:0][DATA_WIDTH-1:0]  res_wdata_i,
    output logic                                 rf_we_o,
    output logic [4:0]                           rf_waddr_o,
    output logic [DATA_WIDTH-1:0]                rf_wdata_o,
    output logic [31:0]                          busy_o
);

    localparam int              PTR_W      = (NR_UNITS > 1) ? $clog2(NR_UNITS) : 1;
    localparam logic [PTR_W:0]  NR_UNITS_C = (PTR_W+1)'(NR_UNITS);

    logic [31:0]           busy_q, busy_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  rf_we_q;
    logic [4:0]            rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    logic                  grant_valid;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W:0]        cand;
    logic [PTR_W:0]        ptr_inc;
    logic [NR_UNITS-1:0]   res_ready;
    logic [4:0]            sel_waddr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  issue_fire;

    // Hazard check against the current scoreboard; no bypass from the
    // write port, the clear becomes visible one cycle after rf_we_o.
    always_comb begin
        issue_ready_o = ~(busy_q[issue_rs1_i] | busy_q[issue_rs2_i]
                          | (issue_rd_we_i & busy_q[issue_rd_i]));
        issue_fire    = issue_valid_i & issue_ready_o;
    end

    // Round-robin search starting at ptr_q, wrapping modulo NR_UNITS.
    // The modulo is a single conditional subtract since ptr_q + off
    // never reaches 2*NR_UNITS.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NR_UNITS; off++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
            if (cand >= NR_UNITS_C) begin
                cand = cand - NR_UNITS_C;
            end
            if (!grant_valid && res_valid_i[cand[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        res_ready = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int u = 0; u < NR_UNITS; u++) begin
            if (grant_valid && (grant_idx == PTR_W'(u))) begin
                res_ready[u] = 1'b1;
                sel_waddr    = res_waddr_i[u];
                sel_wdata    = res_wdata_i[u];
            end
        end
    end

    assign res_ready_o = res_ready;

    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (ptr_inc == NR_UNITS_C) begin
            ptr_inc = '0;
        end
        ptr_d = grant_valid ? ptr_inc[PTR_W-1:0] : ptr_q;
    end

    // Clear first, then set, so an issue to the register being written
    // back in the same cycle leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_fire && issue_rd_we_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            rf_we_q <= grant_valid;
            if (grant_valid) begin
                rf_waddr_q <= sel_waddr;
                rf_wdata_q <= sel_wdata;
            end
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_xif_copro_wb_scheduler.sv
module tb_xif_copro_wb_scheduler;

    localparam int NR = 3;
    localparam int DW = 32;

    logic                    clk;
    logic                    rst;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [4:0]              issue_rs1, issue_rs2, issue_rd;
    logic                    issue_rd_we;
    logic [NR-1:0]           res_valid;
    logic [NR-1:0]           res_ready;
    logic [NR-1:0][4:0]      res_waddr;
    logic [NR-1:0][DW-1:0]   res_wdata;
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [DW-1:0]           rf_wdata;
    logic [31:0]             busy;

    int n_vec = 0;
    int n_err = 0;

    xif_copro_wb_scheduler #(.DATA_WIDTH(DW), .NR_UNITS(NR)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_rs1_i   (issue_rs1),
        .issue_rs2_i   (issue_rs2),
        .issue_rd_i    (issue_rd),
        .issue_rd_we_i (issue_rd_we),
        .res_valid_i   (res_valid),
        .res_ready_o   (res_ready),
        .res_waddr_i   (res_waddr),
        .res_wdata_i   (res_wdata),
        .rf_we_o       (rf_we),
        .rf_waddr_o    (rf_waddr),
        .rf_wdata_o    (rf_wdata),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of pending registers, arbiter pointer, and
    // the write that is currently on the register-file port.
    bit [31:0]  m_busy;
    int         m_ptr;
    bit         m_we;
    bit [4:0]   m_waddr;
    bit [DW-1:0] m_wdata;

    function automatic bit m_ready(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic we);
        return !(m_busy[rs1] || m_busy[rs2] || (we && m_busy[rd]));
    endfunction

    function automatic int m_grant(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] m_onehot(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock edge, updating the model from the inputs in force.
    task automatic tick();
        int        g;
        bit        fire;
        bit [31:0] nb;
        g    = m_grant(res_valid);
        fire = issue_valid && m_ready(issue_rs1, issue_rs2, issue_rd, issue_rd_we);
        nb   = m_busy;
        if (m_we) nb[m_waddr] = 1'b0;
        if (fire && issue_rd_we) nb[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = '0; m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_busy = nb;
            m_we   = (g >= 0);
            if (g >= 0) begin
                m_ptr   = (g + 1) % NR;
                m_waddr = res_waddr[g];
                m_wdata = res_wdata[g];
            end
        end
    endtask

    task automatic drive_idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
        res_valid = '0; res_waddr = '0; res_wdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR-1:0] exp_rr;
        // random inputs while reset is held
        rst         = 1'b1;
        issue_valid = 1'b1;
        issue_rs1   = 5'($urandom_range(0, 31));
        issue_rs2   = 5'($urandom_range(0, 31));
        issue_rd    = 5'($urandom_range(0, 31));
        issue_rd_we = 1'b1;
        res_valid   = NR'($urandom_range(1, 7));
        for (int u = 0; u < NR; u++) begin
            res_waddr[u] = 5'($urandom);
            res_wdata[u] = $urandom;
        end
        #1;
        exp_rr = '0;
        for (int u = NR - 1; u >= 0; u--) if (res_valid[u]) exp_rr = NR'(1) << u;
        n_vec++;
        if (res_ready !== exp_rr) begin
            n_err++; $display("FAIL reset_res_ready got %b exp %b", res_ready, exp_rr);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if (busy !== 32'h0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_vec++;
        if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
        n_vec++;
        if (rf_waddr !== 5'd0 || rf_wdata !== '0) begin
            n_err++; $display("FAIL reset_rf_addr_data got %h/%h exp 0/0", rf_waddr, rf_wdata);
        end
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom);
            issue_rd = 5'($urandom); issue_rd_we = 1'b1;
            #1;
            n_vec++;
            if (issue_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready);
            end
        end
        drive_idle();
    endtask

    task automatic test_hazard();
        drive_idle();
        apply_reset();
        issue_valid = 1; issue_rd = 5; issue_rd_we = 1;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL hazard_c0_ready got %b exp 1", issue_ready); end
        tick();
        n_vec++;
        if (busy !== 32'h20) begin n_err++; $display("FAIL hazard_c1_busy got %h exp 00000020", busy); end
        issue_rs1 = 5; issue_rd = 6;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_vec++;
            if (issue_ready !== 1'b0) begin n_err++; $display("FAIL hazard_stall got %b exp 0", issue_ready); end
            tick();
        end
        res_valid = 3'b001; res_waddr[0] = 5; res_wdata[0] = 32'hDEADBEEF;
        #1;
        n_vec++;
        if (res_ready !== 3'b001) begin n_err++; $display("FAIL hazard_c3_res_ready got %b exp 001", res_ready); end
        tick();
        res_valid = '0;
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL hazard_c4_wb got %b/%0d/%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        #1;
        n_vec++;
        if (issue_ready !== 1'b0) begin n_err++; $display("FAIL hazard_c4_stall got %b exp 0", issue_ready); end
        tick();
        n_vec++;
        if (busy !== 32'h0 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL hazard_c5_clear got busy %h we %b exp 0/0", busy, rf_we);
        end
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL hazard_c5_fire got %b exp 1", issue_ready); end
        tick();
        n_vec++;
        if (busy !== 32'h40) begin n_err++; $display("FAIL hazard_c6_busy got %h exp 00000040", busy); end
        drive_idle();
    endtask

    task automatic test_fairness();
        logic [4:0]    ea;
        logic [DW-1:0] ed;
        drive_idle();
        res_valid = 3'b111;
        for (int u = 0; u < NR; u++) begin res_waddr[u] = 5'($urandom); res_wdata[u] = $urandom; end
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            #1;
            n_vec++;
            if (res_ready !== (3'b001 << (k % 3))) begin
                n_err++; $display("FAIL fair_grant k=%0d got %b exp %b", k, res_ready, 3'b001 << (k % 3));
            end
            ea = res_waddr[k % 3]; ed = res_wdata[k % 3];
            tick();
            n_vec++;
            if (rf_we !== 1'b1 || rf_waddr !== ea || rf_wdata !== ed) begin
                n_err++; $display("FAIL fair_wb k=%0d got %b/%h/%h exp 1/%h/%h", k, rf_we, rf_waddr, rf_wdata, ea, ed);
            end
            res_waddr[k % 3] = 5'($urandom); res_wdata[k % 3] = $urandom;
        end
        drive_idle();
    endtask

    task automatic test_wrap();
        drive_idle();
        apply_reset();
        for (int u = 0; u < NR; u++) begin res_waddr[u] = 5'(u + 20); res_wdata[u] = $urandom; end
        res_valid = 3'b010;
        tick();
        res_valid = 3'b001;
        #1;
        n_vec++;
        if (res_ready !== 3'b001) begin n_err++; $display("FAIL wrap_to_0 got %b exp 001", res_ready); end
        tick();
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd20) begin
            n_err++; $display("FAIL wrap_wb0 got %b/%0d exp 1/20", rf_we, rf_waddr);
        end
        res_valid = 3'b110;
        #1;
        n_vec++;
        if (res_ready !== 3'b010) begin n_err++; $display("FAIL wrap_ptr1 got %b exp 010", res_ready); end
        tick();
        n_vec++;
        if (rf_waddr !== 5'd21) begin n_err++; $display("FAIL wrap_wb1 got %0d exp 21", rf_waddr); end
        drive_idle();
    endtask

    task automatic test_same_edge();
        logic [DW-1:0] d;
        drive_idle();
        apply_reset();
        d = $urandom;
        res_valid = 3'b001; res_waddr[0] = 7; res_wdata[0] = d;
        tick();
        res_valid = '0;
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== d || busy[7] !== 1'b0) begin
            n_err++; $display("FAIL same_wb_nonbusy got %b/%0d/%h busy7 %b exp 1/7/%h/0", rf_we, rf_waddr, rf_wdata, busy[7], d);
        end
        issue_valid = 1; issue_rd = 7; issue_rd_we = 1;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL same_ready got %b exp 1", issue_ready); end
        tick();
        n_vec++;
        if (busy !== 32'h80) begin n_err++; $display("FAIL same_set_wins got %h exp 00000080", busy); end
        drive_idle();
    endtask

    task automatic test_mid_reset();
        drive_idle();
        apply_reset();
        for (int r = 8; r < 12; r++) begin
            issue_valid = 1; issue_rd = 5'(r); issue_rd_we = 1;
            tick();
        end
        drive_idle();
        n_vec++;
        if (busy !== 32'h00000F00) begin n_err++; $display("FAIL midrst_setup got %h exp 00000f00", busy); end
        res_valid = 3'b001; res_waddr[0] = 8; res_wdata[0] = $urandom;
        tick();
        rst = 1'b1;
        res_valid = 3'b010; res_waddr[1] = 9; res_wdata[1] = $urandom;
        issue_valid = 1; issue_rd = 12; issue_rd_we = 1;
        #1;
        n_vec++;
        if (res_ready !== 3'b010) begin n_err++; $display("FAIL midrst_res_ready got %b exp 010", res_ready); end
        tick();
        rst = 1'b0;
        drive_idle();
        n_vec++;
        if (busy !== 32'h0 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL midrst_clear got busy %h we %b exp 0/0", busy, rf_we);
        end
        res_valid = 3'b111;
        #1;
        n_vec++;
        if (res_ready !== 3'b001) begin n_err++; $display("FAIL midrst_ptr got %b exp 001", res_ready); end
        drive_idle();
    endtask

    task automatic test_random();
        int g;
        drive_idle();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int u = 0; u < NR; u++) begin
                if (!res_valid[u] && ($urandom_range(0, 2) != 0)) begin
                    res_valid[u] = 1'b1;
                    res_waddr[u] = 5'($urandom_range(0, 7));
                    res_wdata[u] = $urandom;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rd_we = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 99) == 0);
            #1;
            g = m_grant(res_valid);
            n_vec++;
            if (issue_ready !== m_ready(issue_rs1, issue_rs2, issue_rd, issue_rd_we)) begin
                n_err++; $display("FAIL rand_issue_ready c=%0d got %b exp %b", c, issue_ready, m_ready(issue_rs1, issue_rs2, issue_rd, issue_rd_we));
            end
            n_vec++;
            if (res_ready !== m_onehot(g)) begin
                n_err++; $display("FAIL rand_res_ready c=%0d got %b exp %b", c, res_ready, m_onehot(g));
            end
            tick();
            n_vec++;
            if (busy !== m_busy) begin
                n_err++; $display("FAIL rand_busy c=%0d got %h exp %h", c, busy, m_busy);
            end
            n_vec++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                n_err++; $display("FAIL rand_wb c=%0d got %b/%h/%h exp %b/%h/%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            if (!rst && g >= 0) res_valid[g] = 1'b0;
            rst = 1'b0;
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        m_busy = '0; m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        tick();
        test_reset();
        test_hazard();
        test_fairness();
        test_wrap();
        test_same_edge();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xif_copro_wb_scheduler.md
XIF_COPRO_WB_SCHEDULER -- requirements
Module: xif_copro_wb_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of register data.
REQ-002 Parameter NR_UNITS, default 3: number of result-producing functional units; legal range 2..8.
REQ-003 clk_i  input  1: sole clock, all state updates on its rising edge.
REQ-004 rst_i  input  1: reset, synchronous and active-high.
REQ-005 issue_valid_i  input  1: instruction offered for issue.
REQ-006 issue_ready_o  output  1: instruction may issue this cycle.
REQ-007 issue_rs1_i, issue_rs2_i  input  5 each: source register addresses.
REQ-008 issue_rd_i  input  5: destination register address.
REQ-009 issue_rd_we_i  input  1: instruction writes issue_rd_i.
REQ-010 res_valid_i  input  NR_UNITS: per-unit result valid.
REQ-011 res_ready_o  output  NR_UNITS: per-unit result accepted.
REQ-012 res_waddr_i  input  NR_UNITS x 5: per-unit destination address.
REQ-013 res_wdata_i  input  NR_UNITS x DATA_WIDTH: per-unit result data.
REQ-014 rf_we_o  output  1: register-file write enable, one write port.
REQ-015 rf_waddr_o  output  5: register-file write address.
REQ-016 rf_wdata_o  output  DATA_WIDTH: register-file write data.
REQ-017 busy_o  output  32: scoreboard, bit i set = write to register i pending.

Function
REQ-018 issue_ready_o SHALL be combinational: NOT(busy[rs1] OR busy[rs2] OR (issue_rd_we_i AND busy[rd])); RAW and WAW hazards stall.
REQ-019 Issue fires when issue_valid_i AND issue_ready_o; if issue_rd_we_i, busy[issue_rd_i] SHALL be set at the next edge.
REQ-020 Arbiter SHALL be round-robin: grant g = first unit with res_valid_i set, searching from pointer ptr upward with wrap-around modulo NR_UNITS.
REQ-021 res_ready_o SHALL be one-hot at bit g when any res_valid_i set, all-zero otherwise; combinational from res_valid_i and ptr.
REQ-022 On a grant, ptr SHALL become (g+1) mod NR_UNITS at the next edge; with no valid unit ptr SHALL hold.
REQ-023 Granted result SHALL be registered: rf_we_o=1, rf_waddr_o=res_waddr_i[g], rf_wdata_o=res_wdata_i[g] in the cycle after the grant (latency 1); rf_we_o=0 in cycles following no grant, rf_waddr_o/rf_wdata_o then hold.
REQ-024 In a cycle with rf_we_o=1, busy[rf_waddr_o] SHALL clear at the next edge, the same edge the register file commits the data; an instruction issued the following cycle reads the new value.
REQ-025 Simultaneous set (issue) and clear (write-back) of the same bit: set SHALL win.
REQ-026 Write-back to a non-busy address SHALL still be performed; busy unchanged.
REQ-027 One result per cycle maximum; ungranted units SHALL hold valid and data until granted (units may not make valid depend on ready).
REQ-028 Throughput: continuous valid on all units SHALL yield one write every cycle with no bubbles.

Reset
REQ-029 While rst_i=1 at an edge: busy_o=0, ptr=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-030 Reset mid-operation SHALL drop all pending busy bits and suppress the registered write; no rf_we_o pulse in the cycle after a reset edge.
REQ-031 During reset, issue_ready_o and res_ready_o SHALL follow REQ-018/REQ-021 on reset state, but no state change other than REQ-029 occurs.

Verification
REQ-032 Reset: hold rst_i 1 cycle with random inputs -> busy_o=0, rf_we_o=0, issue_ready_o=1 for any sources next cycle.
REQ-033 Hazard: issue rd=5 we=1 at cycle 0 -> busy_o[5]=1 cycle 1; issue rs1=5 stalls; unit0 result waddr=5 data=0xDEADBEEF cycle 3 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF cycle 4; busy_o[5]=0 and stalled issue fires cycle 5.
REQ-034 Fairness: units 0,1,2 valid continuously from reset -> grants 0,1,2,0,1,2, rf_we_o=1 every cycle from cycle 1.
REQ-035 Wrap: ptr=2, only unit 0 valid -> grant 0, ptr=1; then only unit 1 and 2 valid -> grant 1.
REQ-036 Same-edge set/clear: rf_we_o=1 waddr=7 with busy_o[7]=0 while issuing rd=7 -> busy_o[7]=1 next cycle.
REQ-037 Mid-operation reset: busy_o=0x00000F00, grant pending, rst_i=1 -> next cycle busy_o=0, rf_we_o=0.
